network_v_fwd: RTL and testbench

Parametrised per-lane operand network for the vector unit. For each of `NUM_SRC` source operands it selects one of four sources: own register-file data, scalar broadcast, any lane's data via a lane crossbar, or zero. RF-sourced operands are then forwarded from a depth-configurable bypass CAM-FIFO of in-flight write-backs. Results leave through a registered, stallable output stage. The block sits between the vector register-read stage and the lane execution unit, one instance per lane.

---
 rtl/network_v_fwd_pkg.sv | 21 ++
 rtl/network_v_fwd_if.sv | 43 ++++
 rtl/network_v_fwd_bypass_fifo_v.sv | 98 +++++++++
 rtl/network_v_fwd.sv | 96 +++++++++
 tb/tb_network_v_fwd.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/network_v_fwd_pkg.sv
// pkg_tpu: shared types and defaults for the vector-lane operand network.
//   data_t / index_t   : operand and register-index types at default widths
//   sel_src_t          : per-operand source select encoding
//   BYPASS_BUFF_SIZE   : default depth of the write-back bypass buffer
package pkg_tpu;

  localparam int WIDTH_DATA_DEF   = 32;
  localparam int WIDTH_INDEX_DEF  = 8;
  localparam int BYPASS_BUFF_SIZE = 8;

  typedef logic [WIDTH_DATA_DEF-1:0]  data_t;
  typedef logic [WIDTH_INDEX_DEF-1:0] index_t;

  typedef enum logic [1:0] {
    SRC_RF     = 2'd0,
    SRC_SCALAR = 2'd1,
    SRC_LANE   = 2'd2,
    SRC_ZERO   = 2'd3
  } sel_src_t;

endpackage

// File: rtl/network_v_fwd_if.sv
// network_v_fwd_if: operand request / write-back / result bundle of one lane.
//   master : register-read stage + write-back path (drives I_*, sees O_*)
//   slave  : the operand network (sees I_*, drives O_*)
interface network_v_fwd_if import pkg_tpu::*; #(
  parameter int NUM_LANES   = 16,
  parameter int NUM_SRC     = 3,
  parameter int WIDTH_DATA  = WIDTH_DATA_DEF,
  parameter int WIDTH_INDEX = WIDTH_INDEX_DEF
);
  localparam int WIDTH_LANES = $clog2(NUM_LANES);

  logic                               I_Stall;
  logic                               I_Req;
  logic [2*NUM_SRC-1:0]               I_Sel_Src;
  logic [WIDTH_LANES*NUM_SRC-1:0]     I_Sel_Lane;
  logic [WIDTH_DATA-1:0]              I_Scalar_Data;
  logic [WIDTH_DATA*NUM_LANES-1:0]    I_Lane_Data;
  logic [WIDTH_DATA*NUM_SRC-1:0]      I_Src_Data;
  logic [WIDTH_INDEX*NUM_SRC-1:0]     I_Src_Idx;
  logic                               I_WB_Req;
  logic [WIDTH_INDEX-1:0]             I_WB_Index;
  logic [WIDTH_DATA-1:0]              I_WB_Data;
  logic                               I_Commit;
  logic                               O_Valid;
  logic [WIDTH_DATA*NUM_SRC-1:0]      O_Src_Data;
  logic [NUM_SRC-1:0]                 O_Hit;
  logic                               O_Buff_Full;
  logic                               O_Buff_Empty;
  logic                               O_Overflow;

  modport master (
    output I_Stall, I_Req, I_Sel_Src, I_Sel_Lane, I_Scalar_Data, I_Lane_Data,
           I_Src_Data, I_Src_Idx, I_WB_Req, I_WB_Index, I_WB_Data, I_Commit,
    input  O_Valid, O_Src_Data, O_Hit, O_Buff_Full, O_Buff_Empty, O_Overflow
  );

  modport slave (
    input  I_Stall, I_Req, I_Sel_Src, I_Sel_Lane, I_Scalar_Data, I_Lane_Data,
           I_Src_Data, I_Src_Idx, I_WB_Req, I_WB_Index, I_WB_Data, I_Commit,
    output O_Valid, O_Src_Data, O_Hit, O_Buff_Full, O_Buff_Empty, O_Overflow
  );

endinterface

// File: rtl/network_v_fwd_bypass_fifo_v.sv
// bypass_fifo_v: circular FIFO of in-flight write-backs {index, data} with
// NUM_SRC parallel youngest-match lookups.
//   clock, reset (async, active-low)
//   wb_req/wb_index/wb_data : push;  commit : pop oldest
//   lk_index -> lk_hit/lk_data : per-source forwarding lookup
//   buff_full/buff_empty : registered from post-update count
//   overflow : sticky, a push was dropped while full
// Macro NETWORK_V_SAME_CYCLE_FWD_EN: when defined, the write-back presented
// this cycle is also compared and wins over stored entries.
module bypass_fifo_v import pkg_tpu::*; #(
  parameter int BUFF_DEPTH  = BYPASS_BUFF_SIZE,
  parameter int NUM_SRC     = 3,
  parameter int WIDTH_DATA  = WIDTH_DATA_DEF,
  parameter int WIDTH_INDEX = WIDTH_INDEX_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wb_req,
  input  logic [WIDTH_INDEX-1:0]         wb_index,
  input  logic [WIDTH_DATA-1:0]          wb_data,
  input  logic                           commit,
  input  logic [NUM_SRC*WIDTH_INDEX-1:0] lk_index,
  output logic [NUM_SRC-1:0]             lk_hit,
  output logic [NUM_SRC*WIDTH_DATA-1:0]  lk_data,
  output logic                           buff_full,
  output logic                           buff_empty,
  output logic                           overflow
);
  localparam int WIDTH_PTR = $clog2(BUFF_DEPTH);
  localparam int WIDTH_CNT = WIDTH_PTR + 1;
  localparam logic [WIDTH_CNT-1:0] CNT_FULL = WIDTH_CNT'(BUFF_DEPTH);

  logic [WIDTH_INDEX-1:0] idx_mem  [BUFF_DEPTH];
  logic [WIDTH_DATA-1:0]  data_mem [BUFF_DEPTH];
  logic [WIDTH_PTR-1:0]   wr_ptr, rd_ptr, pos;
  logic [WIDTH_CNT-1:0]   count, count_nxt;
  logic                   do_push, do_pop;

  // A pop frees a slot in the same cycle, so push+pop while full still pushes.
  always_comb begin
    do_pop    = commit && (count != '0);
    do_push   = wb_req && ((count != CNT_FULL) || do_pop);
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  // Storage needs no reset: entries beyond count are never looked at.
  always_ff @(posedge clock) begin
    if (do_push) begin
      idx_mem[wr_ptr]  <= wb_index;
      data_mem[wr_ptr] <= wb_data;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      buff_full  <= 1'b0;
      buff_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      buff_full  <= (count_nxt == CNT_FULL);
      buff_empty <= (count_nxt == '0);
      if (wb_req && !do_push) overflow <= 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    pos     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < BUFF_DEPTH; i++) begin
        pos = rd_ptr + WIDTH_PTR'(i);
        if ((WIDTH_CNT'(i) < count) &&
            (idx_mem[pos] == lk_index[s*WIDTH_INDEX +: WIDTH_INDEX])) begin
          lk_hit[s] = 1'b1;
          lk_data[s*WIDTH_DATA +: WIDTH_DATA] = data_mem[pos];
        end
      end
`ifdef NETWORK_V_SAME_CYCLE_FWD_EN
      if (wb_req && (wb_index == lk_index[s*WIDTH_INDEX +: WIDTH_INDEX])) begin
        lk_hit[s] = 1'b1;
        lk_data[s*WIDTH_DATA +: WIDTH_DATA] = wb_data;
      end
`endif
    end
  end

endmodule

// File: rtl/network_v_fwd.sv
// network_v_fwd: per-lane operand network. Per source operand selects own RF
// data, scalar broadcast, a crossbar lane, or zero; RF operands are forwarded
// from the write-back bypass buffer; results go through a stallable register.
//   clock, reset (async, active-low)
//   bus (network_v_fwd_if.slave) : request, write-back and result signals
// Macro NETWORK_V_SAME_CYCLE_FWD_EN: enables same-cycle write-back forwarding
// (see bypass_fifo_v); undefined, write-backs are visible one cycle after push.
module network_v_fwd import pkg_tpu::*; #(
  parameter int NUM_LANES   = 16,
  parameter int LANE_ID     = 0,
  parameter int NUM_SRC     = 3,
  parameter int BUFF_DEPTH  = BYPASS_BUFF_SIZE,
  parameter int WIDTH_DATA  = WIDTH_DATA_DEF,
  parameter int WIDTH_INDEX = WIDTH_INDEX_DEF
) (
  input logic            clock,
  input logic            reset,
  network_v_fwd_if.slave bus
);
  localparam int WIDTH_LANES = $clog2(NUM_LANES);

  logic [NUM_SRC-1:0]            fwd_hit;
  logic [NUM_SRC*WIDTH_DATA-1:0] fwd_data;
  logic [NUM_SRC*WIDTH_DATA-1:0] sel_data;
  logic [NUM_SRC-1:0]            sel_hit;
  sel_src_t                      src_sel;
  logic [WIDTH_LANES-1:0]        lane;
  logic                          accept;

  bypass_fifo_v #(
    .BUFF_DEPTH  (BUFF_DEPTH),
    .NUM_SRC     (NUM_SRC),
    .WIDTH_DATA  (WIDTH_DATA),
    .WIDTH_INDEX (WIDTH_INDEX)
  ) u_bypass (
    .clock      (clock),
    .reset      (reset),
    .wb_req     (bus.I_WB_Req),
    .wb_index   (bus.I_WB_Index),
    .wb_data    (bus.I_WB_Data),
    .commit     (bus.I_Commit),
    .lk_index   (bus.I_Src_Idx),
    .lk_hit     (fwd_hit),
    .lk_data    (fwd_data),
    .buff_full  (bus.O_Buff_Full),
    .buff_empty (bus.O_Buff_Empty),
    .overflow   (bus.O_Overflow)
  );

  always_comb begin
    sel_data = '0;
    sel_hit  = '0;
    src_sel  = SRC_ZERO;
    lane     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_sel = sel_src_t'(bus.I_Sel_Src[2*s +: 2]);
      lane    = bus.I_Sel_Lane[s*WIDTH_LANES +: WIDTH_LANES];
      case (src_sel)
        SRC_RF: begin
          if (fwd_hit[s]) begin
            sel_data[s*WIDTH_DATA +: WIDTH_DATA] = fwd_data[s*WIDTH_DATA +: WIDTH_DATA];
            sel_hit[s] = 1'b1;
          end else begin
            sel_data[s*WIDTH_DATA +: WIDTH_DATA] = bus.I_Src_Data[s*WIDTH_DATA +: WIDTH_DATA];
          end
        end
        SRC_SCALAR: sel_data[s*WIDTH_DATA +: WIDTH_DATA] = bus.I_Scalar_Data;
        SRC_LANE: begin
          // Own lane comes from the local read port, not the crossbar copy.
          if (lane == WIDTH_LANES'(LANE_ID))
            sel_data[s*WIDTH_DATA +: WIDTH_DATA] = bus.I_Src_Data[s*WIDTH_DATA +: WIDTH_DATA];
          else
            sel_data[s*WIDTH_DATA +: WIDTH_DATA] = bus.I_Lane_Data[lane*WIDTH_DATA +: WIDTH_DATA];
        end
        default: sel_data[s*WIDTH_DATA +: WIDTH_DATA] = '0;
      endcase
    end
  end

  assign accept = bus.I_Req && !bus.I_Stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.O_Valid    <= 1'b0;
      bus.O_Src_Data <= '0;
      bus.O_Hit      <= '0;
    end else begin
      bus.O_Valid <= accept;
      if (accept) begin
        bus.O_Src_Data <= sel_data;
        bus.O_Hit      <= sel_hit;
      end
    end
  end

endmodule

// File: tb/tb_network_v_fwd.sv
module tb_network_v_fwd;
  import pkg_tpu::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  network_v_fwd_if #(.NUM_LANES(16), .NUM_SRC(3), .WIDTH_DATA(32), .WIDTH_INDEX(8)) bus ();

  network_v_fwd #(
    .NUM_LANES(16), .LANE_ID(0), .NUM_SRC(3), .BUFF_DEPTH(8),
    .WIDTH_DATA(32), .WIDTH_INDEX(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.I_Stall       = 1'b0;
    bus.I_Req         = 1'b0;
    bus.I_Sel_Src     = '0;
    bus.I_Sel_Lane    = '0;
    bus.I_Scalar_Data = '0;
    bus.I_Src_Data    = '0;
    bus.I_Src_Idx     = '0;
    bus.I_WB_Req      = 1'b0;
    bus.I_WB_Index    = '0;
    bus.I_WB_Data     = '0;
    bus.I_Commit      = 1'b0;
    for (int i = 0; i < 16; i++) bus.I_Lane_Data[i*32 +: 32] = 32'h100 + 32'(i);
    bus.I_Lane_Data[5*32 +: 32] = 32'h55;

    // reset state
    #12;
    check("rst_valid", bus.O_Valid, 1'b0);
    check("rst_data",  bus.O_Src_Data, 96'h0);
    check("rst_hit",   bus.O_Hit, 3'b000);
    check("rst_full",  bus.O_Buff_Full, 1'b0);
    check("rst_empty", bus.O_Buff_Empty, 1'b1);
    check("rst_ovf",   bus.O_Overflow, 1'b0);
    reset = 1'b1;

    // scalar broadcast to all sources
    bus.I_Req         = 1'b1;
    bus.I_Sel_Src     = {2'd1, 2'd1, 2'd1};
    bus.I_Scalar_Data = 32'hA5A5_0001;
    bus.I_Src_Data    = {32'h1, 32'h2, 32'h3};
    tick();
    check("scalar_valid", bus.O_Valid, 1'b1);
    check("scalar_data",  bus.O_Src_Data, {3{32'hA5A5_0001}});
    check("scalar_hit",   bus.O_Hit, 3'b000);

    // s0 lane 5, s1 zero, s2 own RF
    bus.I_Sel_Src  = {2'd0, 2'd3, 2'd2};
    bus.I_Sel_Lane = {4'd0, 4'd0, 4'd5};
    bus.I_Src_Data = {32'h77, 32'h66, 32'hDEAD_0000};
    tick();
    check("lane5_data", bus.O_Src_Data, {32'h77, 32'h0, 32'h55});
    check("lane5_hit",  bus.O_Hit, 3'b000);

    // own lane through crossbar returns own RF data
    bus.I_Sel_Lane = {4'd0, 4'd0, 4'd0};
    tick();
    check("ownlane_data", bus.O_Src_Data, {32'h77, 32'h0, 32'hDEAD_0000});

    // youngest-match forwarding
    bus.I_Req      = 1'b0;
    bus.I_WB_Req   = 1'b1;
    bus.I_WB_Index = 8'd7;
    bus.I_WB_Data  = 32'h11;
    tick();
    bus.I_WB_Data  = 32'h22;
    tick();
    bus.I_WB_Req   = 1'b0;
    check("push_empty", bus.O_Buff_Empty, 1'b0);
    bus.I_Req      = 1'b1;
    bus.I_Sel_Src  = {2'd0, 2'd0, 2'd0};
    bus.I_Src_Idx  = {8'd7, 8'd3, 8'd7};
    bus.I_Src_Data = {3{32'h99}};
    tick();
    check("young_data", bus.O_Src_Data, {32'h22, 32'h99, 32'h22});
    check("young_hit",  bus.O_Hit, 3'b101);

    // drain, then pop while empty is ignored
    bus.I_Req    = 1'b0;
    bus.I_Commit = 1'b1;
    tick();
    tick();
    check("drain_empty", bus.O_Buff_Empty, 1'b1);
    tick();
    bus.I_Commit = 1'b0;
    check("popempty_empty", bus.O_Buff_Empty, 1'b1);
    check("popempty_full",  bus.O_Buff_Full, 1'b0);
    bus.I_Req     = 1'b1;
    bus.I_Src_Idx = {8'd7, 8'd7, 8'd7};
    tick();
    check("drained_data", bus.O_Src_Data, {3{32'h99}});
    check("drained_hit",  bus.O_Hit, 3'b000);

    // same-cycle write-back
    bus.I_Src_Idx  = {8'd4, 8'd4, 8'd4};
    bus.I_WB_Req   = 1'b1;
    bus.I_WB_Index = 8'd4;
    bus.I_WB_Data  = 32'h44;
    tick();
`ifdef NETWORK_V_SAME_CYCLE_FWD_EN
    check("samecyc_data", bus.O_Src_Data, {3{32'h44}});
    check("samecyc_hit",  bus.O_Hit, 3'b111);
`else
    check("samecyc_data", bus.O_Src_Data, {3{32'h99}});
    check("samecyc_hit",  bus.O_Hit, 3'b000);
`endif
    bus.I_WB_Req = 1'b0;
    tick();
    check("nextcyc_data", bus.O_Src_Data, {3{32'h44}});
    check("nextcyc_hit",  bus.O_Hit, 3'b111);

    // fill to full (one entry already held)
    bus.I_Req    = 1'b0;
    bus.I_WB_Req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.I_WB_Index = 8'(10 + i);
      bus.I_WB_Data  = 32'h1000 + 32'(i);
      tick();
    end
    check("seven_full", bus.O_Buff_Full, 1'b0);
    bus.I_WB_Index = 8'd16;
    bus.I_WB_Data  = 32'h1006;
    tick();
    check("eight_full",  bus.O_Buff_Full, 1'b1);
    check("eight_empty", bus.O_Buff_Empty, 1'b0);

    // push + pop while full
    bus.I_WB_Index = 8'd20;
    bus.I_WB_Data  = 32'h2020;
    bus.I_Commit   = 1'b1;
    tick();
    bus.I_Commit   = 1'b0;
    check("pushpop_full", bus.O_Buff_Full, 1'b1);
    check("pushpop_ovf",  bus.O_Overflow, 1'b0);

    // lone push while full is dropped
    bus.I_WB_Index = 8'd30;
    bus.I_WB_Data  = 32'h3030;
    tick();
    bus.I_WB_Req   = 1'b0;
    check("drop_ovf",  bus.O_Overflow, 1'b1);
    check("drop_full", bus.O_Buff_Full, 1'b1);
    bus.I_Req     = 1'b1;
    bus.I_Src_Idx = {8'd4, 8'd20, 8'd30};
    tick();
    check("drop_data", bus.O_Src_Data, {32'h99, 32'h2020, 32'h99});
    check("drop_hit",  bus.O_Hit, 3'b010);
    check("ovf_sticky", bus.O_Overflow, 1'b1);

    // stall holds output; buffer still pops
    bus.I_Sel_Src     = {2'd1, 2'd1, 2'd1};
    bus.I_Scalar_Data = 32'hAAAA_0001;
    tick();
    check("stallA_data", bus.O_Src_Data, {3{32'hAAAA_0001}});
    bus.I_Stall       = 1'b1;
    bus.I_Scalar_Data = 32'hBBBB_0002;
    bus.I_Sel_Src     = {2'd0, 2'd0, 2'd0};
    bus.I_Src_Idx     = {8'd20, 8'd20, 8'd20};
    bus.I_Commit      = 1'b1;
    tick();
    bus.I_Commit      = 1'b0;
    check("stall1_data", bus.O_Src_Data, {3{32'hAAAA_0001}});
    check("stall1_hit",  bus.O_Hit, 3'b000);
    check("stall_pop_full", bus.O_Buff_Full, 1'b0);
    tick();
    check("stall2_data", bus.O_Src_Data, {3{32'hAAAA_0001}});

    // reset mid-stall
    reset = 1'b0;
    #2;
    check("mrst_valid", bus.O_Valid, 1'b0);
    check("mrst_data",  bus.O_Src_Data, 96'h0);
    check("mrst_hit",   bus.O_Hit, 3'b000);
    check("mrst_full",  bus.O_Buff_Full, 1'b0);
    check("mrst_empty", bus.O_Buff_Empty, 1'b1);
    check("mrst_ovf",   bus.O_Overflow, 1'b0);
    #1;
    reset = 1'b1;

    // buffer contents discarded by reset
    bus.I_Stall   = 1'b0;
    bus.I_Src_Idx = {8'd10, 8'd20, 8'd30};
    tick();
    check("post_valid", bus.O_Valid, 1'b1);
    check("post_data",  bus.O_Src_Data, {3{32'h99}});
    check("post_hit",   bus.O_Hit, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
